// File: rtl/store_commit_buffer_pkg.sv
// Shared types for the post-LSQ store commit buffer: entry layout, drain FSM states, sizing.
package store_commit_buffer_pkg;

  localparam int ROB_ID_SIZE = 6;
  localparam int SB_DEPTH    = 8;

  typedef enum bit {drain_idle, drain_wait} sb_drain_state_t;

  typedef struct packed {
    logic [ROB_ID_SIZE-1:0] rob_id;
    logic [31:0]            addr;
    logic [3:0]             wmask;
    logic [31:0]            wdata;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_select.sv
// One byte lane of store-to-load forwarding: scans live entries oldest to youngest so the
// youngest matching store that writes this lane wins.
module sb_fwd_select
  import store_commit_buffer_pkg::*;
#(
  parameter  int DEPTH = SB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH) + 1
) (
  input  sb_entry_t        entries [DEPTH],
  input  logic [PTR_W-1:0] head,
  input  logic [PTR_W-1:0] tail,
  input  logic [1:0]       lane,
  input  logic [31:0]      ld_addr,
  output logic             found,
  output logic [7:0]       fwd_byte
);

  localparam int IDX_W = PTR_W - 1;

  logic [PTR_W-1:0] live;
  logic [PTR_W-1:0] ptr;

  // NOTE: every output and temporary gets a default before the loop; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    found    = 1'b0;
    fwd_byte = '0;
    ptr      = head;
    live     = tail - head;
    for (int k = 0; k < DEPTH; k++) begin
      ptr = head + PTR_W'(k);
      if ((PTR_W'(k) < live) &&
          (entries[ptr[IDX_W-1:0]].addr == ld_addr) &&
          entries[ptr[IDX_W-1:0]].wmask[lane]) begin
        found    = 1'b1;
        fwd_byte = entries[ptr[IDX_W-1:0]].wdata[{lane, 3'b000} +: 8];
      end
    end
  end

endmodule

// File: rtl/store_commit_buffer.sv
// Post-LSQ store buffer: holds resolved stores in program order, commits them on ROB retire,
// drains committed stores to the dcache one at a time, and forwards bytes to younger loads.
module store_commit_buffer
  import store_commit_buffer_pkg::*;
#(
  parameter  int DEPTH = SB_DEPTH,
  parameter  int ID_W  = ROB_ID_SIZE,
  localparam int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [ID_W-1:0]  enq_rob_id,
  input  logic [31:0]      enq_addr,
  input  logic [3:0]       enq_wmask,
  input  logic [31:0]      enq_wdata,
  input  logic             commit_valid,
  input  logic [ID_W-1:0]  commit_rob_id,
  input  logic             flush,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  input  logic [3:0]       ld_rmask,
  output logic             fwd_hit,
  output logic             fwd_conflict,
  output logic [31:0]      fwd_data,
  output logic [31:0]      dmem_addr,
  output logic [3:0]       dmem_wmask,
  output logic [31:0]      dmem_wdata,
  input  logic             dmem_resp,
  output logic             sb_empty,
  output logic [PTR_W-1:0] sb_count
);

  localparam int IDX_W = PTR_W - 1;

  sb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] head, cmt, tail;
  logic [PTR_W-1:0] cmt_next, tail_next, head_next;
  logic             enq_fire, commit_fire, head_inc;

  sb_drain_state_t  state, state_next;
  logic [31:0]      dmem_addr_next, dmem_wdata_next;
  logic [3:0]       dmem_wmask_next;

  logic [3:0]       lane_found;
  logic [7:0]       lane_byte [4];
  logic [3:0]       need, got;

  assign sb_count    = tail - head;
  assign sb_empty    = (head == tail);
  assign enq_ready   = (sb_count != PTR_W'(DEPTH));
  assign enq_fire    = enq_valid && enq_ready && !flush;
  assign commit_fire = commit_valid && (cmt != tail);

  // Flush rewinds tail onto the commit point after this cycle's commit has been applied.
  always_comb begin
    cmt_next  = commit_fire ? cmt + 1'b1 : cmt;
    head_next = head_inc ? head + 1'b1 : head;
    if (flush)         tail_next = cmt_next;
    else if (enq_fire) tail_next = tail + 1'b1;
    else               tail_next = tail;
  end

  // NOTE: the entry array has no reset; validity lives entirely in the pointers, so stale
  // contents are never observed and the storage can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (enq_fire)
      entries[tail[IDX_W-1:0]] <= '{rob_id: ROB_ID_SIZE'(enq_rob_id), addr: enq_addr,
                                    wmask: enq_wmask, wdata: enq_wdata};
  end

  // Drain starts as soon as the head entry is committed, including a commit landing this cycle.
  always_comb begin
    state_next      = state;
    dmem_addr_next  = dmem_addr;
    dmem_wmask_next = dmem_wmask;
    dmem_wdata_next = dmem_wdata;
    head_inc        = 1'b0;
    unique case (state)
      drain_idle: begin
        if (head != cmt_next) begin
          dmem_addr_next  = entries[head[IDX_W-1:0]].addr;
          dmem_wmask_next = entries[head[IDX_W-1:0]].wmask;
          dmem_wdata_next = entries[head[IDX_W-1:0]].wdata;
          state_next      = drain_wait;
        end
      end
      drain_wait: begin
        if (dmem_resp) begin
          head_inc        = 1'b1;
          dmem_wmask_next = '0;
          state_next      = drain_idle;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values
  // independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= drain_idle;
      head       <= '0;
      cmt        <= '0;
      tail       <= '0;
      dmem_addr  <= '0;
      dmem_wmask <= '0;
      dmem_wdata <= '0;
    end else begin
      state      <= state_next;
      head       <= head_next;
      cmt        <= cmt_next;
      tail       <= tail_next;
      dmem_addr  <= dmem_addr_next;
      dmem_wmask <= dmem_wmask_next;
      dmem_wdata <= dmem_wdata_next;
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_lane
    sb_fwd_select #(.DEPTH(DEPTH)) u_fwd_select (
      .entries  (entries),
      .head     (head),
      .tail     (tail),
      .lane     (2'(b)),
      .ld_addr  (ld_addr),
      .found    (lane_found[b]),
      .fwd_byte (lane_byte[b])
    );
  end

  always_comb begin
    need         = ld_valid ? ld_rmask : 4'b0000;
    got          = lane_found & need;
    fwd_hit      = (need != 4'b0000) && (got == need);
    fwd_conflict = (got != 4'b0000) && (got != need);
    fwd_data     = '0;
    for (int b = 0; b < 4; b++)
      if (got[b]) fwd_data[8*b +: 8] = lane_byte[b];
  end

  a_commit_has_entry : assert property (@(posedge clk) disable iff (rst)
    commit_valid |-> (cmt != tail))
    else $error("commit with no uncommitted store");

  a_commit_rob_id : assert property (@(posedge clk) disable iff (rst)
    commit_fire |-> (entries[cmt[IDX_W-1:0]].rob_id == ROB_ID_SIZE'(commit_rob_id)))
    else $error("commit_rob_id does not match oldest uncommitted store");

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed bench for store_commit_buffer: drain order, flush, forwarding, backpressure/wrap, reset.
module tb_store_commit_buffer;
  import store_commit_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // DEPTH=8 instance
  logic                   enq_valid = 0, enq_ready, commit_valid = 0, flush = 0, ld_valid = 0;
  logic [ROB_ID_SIZE-1:0] enq_rob_id = '0, commit_rob_id = '0;
  logic [31:0]            enq_addr = '0, enq_wdata = '0, ld_addr = '0, fwd_data;
  logic [3:0]             enq_wmask = '0, ld_rmask = '0, dmem_wmask;
  logic                   fwd_hit, fwd_conflict, dmem_resp = 0, sb_empty;
  logic [31:0]            dmem_addr, dmem_wdata;
  logic [3:0]             sb_count;

  // DEPTH=4 instance
  logic                   enq_valid_4 = 0, enq_ready_4, commit_valid_4 = 0, flush_4 = 0, ld_valid_4 = 0;
  logic [ROB_ID_SIZE-1:0] enq_rob_id_4 = '0, commit_rob_id_4 = '0;
  logic [31:0]            enq_addr_4 = '0, enq_wdata_4 = '0, ld_addr_4 = '0, fwd_data_4;
  logic [3:0]             enq_wmask_4 = '0, ld_rmask_4 = '0, dmem_wmask_4;
  logic                   fwd_hit_4, fwd_conflict_4, dmem_resp_4 = 0, sb_empty_4;
  logic [31:0]            dmem_addr_4, dmem_wdata_4;
  logic [2:0]             sb_count_4;

  store_commit_buffer #(.DEPTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_rob_id(enq_rob_id),
    .enq_addr(enq_addr), .enq_wmask(enq_wmask), .enq_wdata(enq_wdata),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id), .flush(flush),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_rmask(ld_rmask),
    .fwd_hit(fwd_hit), .fwd_conflict(fwd_conflict), .fwd_data(fwd_data),
    .dmem_addr(dmem_addr), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_resp(dmem_resp), .sb_empty(sb_empty), .sb_count(sb_count)
  );

  store_commit_buffer #(.DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid_4), .enq_ready(enq_ready_4), .enq_rob_id(enq_rob_id_4),
    .enq_addr(enq_addr_4), .enq_wmask(enq_wmask_4), .enq_wdata(enq_wdata_4),
    .commit_valid(commit_valid_4), .commit_rob_id(commit_rob_id_4), .flush(flush_4),
    .ld_valid(ld_valid_4), .ld_addr(ld_addr_4), .ld_rmask(ld_rmask_4),
    .fwd_hit(fwd_hit_4), .fwd_conflict(fwd_conflict_4), .fwd_data(fwd_data_4),
    .dmem_addr(dmem_addr_4), .dmem_wmask(dmem_wmask_4), .dmem_wdata(dmem_wdata_4),
    .dmem_resp(dmem_resp_4), .sb_empty(sb_empty_4), .sb_count(sb_count_4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enq_valid = 0; commit_valid = 0; flush = 0; ld_valid = 0; dmem_resp = 0;
    enq_valid_4 = 0; commit_valid_4 = 0; dmem_resp_4 = 0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  task automatic enq(input logic [5:0] id, input logic [31:0] a, input logic [3:0] m,
                     input logic [31:0] d);
    enq_valid = 1; enq_rob_id = id; enq_addr = a; enq_wmask = m; enq_wdata = d;
    tick();
    enq_valid = 0;
  endtask

  task automatic commit(input logic [5:0] id);
    commit_valid = 1; commit_rob_id = id;
    tick();
    commit_valid = 0;
  endtask

  task automatic lookup(input logic [31:0] a, input logic [3:0] m);
    ld_valid = 1; ld_addr = a; ld_rmask = m;
    #1;
  endtask

  function automatic logic [31:0] a4(input int id);
    return 32'h1000 + 32'(id) * 4;
  endfunction

  task automatic enq4(input int id);
    enq_valid_4 = 1; enq_rob_id_4 = 6'(id); enq_addr_4 = a4(id);
    enq_wmask_4 = 4'hF; enq_wdata_4 = 32'(id);
    tick();
    enq_valid_4 = 0;
  endtask

  task automatic commit4(input int id);
    commit_valid_4 = 1; commit_rob_id_4 = 6'(id);
    tick();
    commit_valid_4 = 0;
  endtask

  task automatic drain4(input logic [31:0] exp_addr);
    int n = 0;
    while (dmem_wmask_4 == 4'h0 && n < 8) begin
      tick();
      n++;
    end
    check("d4_drain_mask", 32'(dmem_wmask_4), 32'hF);
    check("d4_drain_addr", dmem_addr_4, exp_addr);
    dmem_resp_4 = 1;
    tick();
    dmem_resp_4 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int nid, ncmt, ndrn;

    // Reset values
    #2;
    check("rst_enq_ready", 32'(enq_ready), 1);
    check("rst_sb_empty", 32'(sb_empty), 1);
    check("rst_sb_count", 32'(sb_count), 0);
    check("rst_dmem_wmask", 32'(dmem_wmask), 0);
    check("rst_fwd_hit", 32'(fwd_hit), 0);
    tick();
    rst = 1'b0;

    // 1: three stores, two commits, two drains
    enq(6'd1, 32'h100, 4'hF, 32'h1111_1111);
    enq(6'd2, 32'h104, 4'hF, 32'h2222_2222);
    enq(6'd3, 32'h108, 4'hF, 32'h3333_3333);
    check("t1_count3", 32'(sb_count), 3);
    commit(6'd1);
    check("t1_first_addr", dmem_addr, 32'h100);
    check("t1_first_mask", 32'(dmem_wmask), 32'hF);
    commit(6'd2);
    check("t1_first_held", dmem_addr, 32'h100);
    dmem_resp = 1; tick(); dmem_resp = 0;
    check("t1_mask_clear", 32'(dmem_wmask), 0);
    tick();
    check("t1_second_addr", dmem_addr, 32'h104);
    check("t1_second_data", dmem_wdata, 32'h2222_2222);
    dmem_resp = 1; tick(); dmem_resp = 0;
    tick();
    check("t1_idle_mask", 32'(dmem_wmask), 0);
    check("t1_count1", 32'(sb_count), 1);
    check("t1_not_empty", 32'(sb_empty), 0);

    // 2: flush with entry0 in flight
    do_reset();
    enq(6'd4, 32'h400, 4'hF, 32'hA0A0_A0A0);
    enq(6'd5, 32'h404, 4'hF, 32'hA1A1_A1A1);
    enq(6'd6, 32'h408, 4'hF, 32'hA2A2_A2A2);
    enq(6'd7, 32'h40C, 4'hF, 32'hA3A3_A3A3);
    commit(6'd4);
    commit(6'd5);
    check("t2_count4", 32'(sb_count), 4);
    flush = 1;
    enq_valid = 1; enq_rob_id = 6'd8; enq_addr = 32'h500; enq_wmask = 4'hF; enq_wdata = 32'h5;
    tick();
    flush = 0; enq_valid = 0;
    check("t2_count_after_flush", 32'(sb_count), 2);
    check("t2_inflight_addr", dmem_addr, 32'h400);
    check("t2_inflight_mask", 32'(dmem_wmask), 32'hF);
    dmem_resp = 1; tick(); dmem_resp = 0;
    tick();
    check("t2_second_addr", dmem_addr, 32'h404);
    dmem_resp = 1; tick(); dmem_resp = 0;
    tick(); tick(); tick();
    check("t2_no_more_drain", 32'(dmem_wmask), 0);
    check("t2_count0", 32'(sb_count), 0);
    check("t2_empty", 32'(sb_empty), 1);
    lookup(32'h408, 4'hF);
    check("t2_flushed_no_fwd", 32'({fwd_hit, fwd_conflict}), 0);
    lookup(32'h500, 4'hF);
    check("t2_dropped_enq_no_fwd", 32'({fwd_hit, fwd_conflict}), 0);
    ld_valid = 0;

    // 3: youngest byte wins
    do_reset();
    enq_valid = 1; enq_rob_id = 6'd1; enq_addr = 32'h200; enq_wmask = 4'hF; enq_wdata = 32'hDEAD_BEEF;
    lookup(32'h200, 4'hF);
    check("t3_same_cycle_invisible", 32'(fwd_hit), 0);
    tick();
    enq_valid = 0;
    check("t3_visible_next", 32'(fwd_hit), 1);
    ld_valid = 0;
    enq(6'd2, 32'h200, 4'b0010, 32'h0000_5500);
    lookup(32'h200, 4'hF);
    check("t3_hit", 32'(fwd_hit), 1);
    check("t3_conflict", 32'(fwd_conflict), 0);
    check("t3_data", fwd_data, 32'hDEAD_55EF);
    lookup(32'h200, 4'b0010);
    check("t3_lane1_data", fwd_data, 32'h0000_5500);
    ld_valid = 0;
    #1;
    check("t3_idle_data", fwd_data, 0);
    check("t3_idle_hit", 32'(fwd_hit), 0);

    // 4: partial coverage -> conflict, other address -> miss
    do_reset();
    enq(6'd1, 32'h300, 4'b0001, 32'h0000_00AB);
    lookup(32'h300, 4'b0011);
    check("t4_conflict", 32'(fwd_conflict), 1);
    check("t4_no_hit", 32'(fwd_hit), 0);
    check("t4_partial_data", fwd_data, 32'h0000_00AB);
    lookup(32'h304, 4'b0011);
    check("t4_miss", 32'({fwd_hit, fwd_conflict}), 0);
    ld_valid = 0;

    // 6: async reset during DRAIN_WAIT
    do_reset();
    enq(6'd1, 32'h600, 4'hF, 32'h6666_6666);
    commit(6'd1);
    check("t6_wait_mask", 32'(dmem_wmask), 32'hF);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_mask", 32'(dmem_wmask), 0);
    check("t6_async_empty", 32'(sb_empty), 1);
    check("t6_async_count", 32'(sb_count), 0);
    rst = 1'b0;

    // 5: DEPTH=4 backpressure and pointer wrap
    do_reset();
    nid = 0; ncmt = 0; ndrn = 0;
    for (int i = 0; i < 4; i++) begin
      enq4(nid);
      nid++;
    end
    check("t5_full_ready", 32'(enq_ready_4), 0);
    check("t5_full_count", 32'(sb_count_4), 4);
    enq_valid_4 = 1; enq_rob_id_4 = 6'(nid); enq_addr_4 = a4(nid);
    enq_wmask_4 = 4'hF; enq_wdata_4 = 32'(nid);
    commit4(ncmt);
    ncmt++;
    enq_valid_4 = 1;
    check("t5_drain0_addr", dmem_addr_4, a4(0));
    check("t5_still_full", 32'(enq_ready_4), 0);
    dmem_resp_4 = 1; tick(); dmem_resp_4 = 0;
    ndrn = 1;
    check("t5_after_pop_count", 32'(sb_count_4), 3);
    check("t5_after_pop_ready", 32'(enq_ready_4), 1);
    tick();
    enq_valid_4 = 0;
    nid++;
    check("t5_held_accepted", 32'(sb_count_4), 4);
    check("t5_full_again", 32'(enq_ready_4), 0);
    while (ncmt < nid) begin commit4(ncmt); ncmt++; end
    while (ndrn < nid) begin drain4(a4(ndrn)); ndrn++; end
    tick();
    check("t5_round0_empty", 32'(sb_empty_4), 1);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin enq4(nid); nid++; end
      check("t5_round_full", 32'(enq_ready_4), 0);
      while (ncmt < nid) begin commit4(ncmt); ncmt++; end
      while (ndrn < nid) begin drain4(a4(ndrn)); ndrn++; end
      tick();
      check("t5_round_empty", 32'(sb_empty_4), 1);
      check("t5_round_count", 32'(sb_count_4), 0);
      check("t5_round_idle", 32'(dmem_wmask_4), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
